meta_demux_1_2: RTL and testbench
=================================

Name: meta_demux_1_2

Overview:
- Splitter counterpart of the 2:1 meta arbiter: one metaIntf source fans out to two metaIntf sinks.
- The sink is selected per transaction by one destination bit inside the meta word.
- Each sink has its own QDEPTH-entry queue, so a stalled sink does not block the other until its own queue fills.
- Sits between a shared command producer and two per-channel consumers (e.g. host/card or rd/wr request paths).

Parameters:
- QDEPTH, 4, entries per output queue; power of two, >= 2.
- DATA_BITS, 96, width of the meta data word; must match the metaIntf instances.
- DEST_BIT, 0, index into data of the routing bit: 0 -> m_meta_0, 1 -> m_meta_1; 0 <= DEST_BIT < DATA_BITS.

Ports:
- aclk, input, 1, clock. All logic is on the rising edge.
- aresetn, input, 1, reset: asynchronous, active-low.
- s_meta, metaIntf.s, valid/ready/DATA_BITS, input stream.
- m_meta_0, metaIntf.m, valid/ready/DATA_BITS, output for DEST_BIT == 0.
- m_meta_1, metaIntf.m, valid/ready/DATA_BITS, output for DEST_BIT == 1.
- used_0, output, $clog2(QDEPTH+1), occupancy of queue 0.
- used_1, output, $clog2(QDEPTH+1), occupancy of queue 1.

Behaviour:
- Reset (asynchronous, aresetn low):
  - Read/write pointers and counts clear; queue storage is not cleared.
  - s_meta.ready = 0, m_meta_x.valid = 0, m_meta_x.data = 0, used_x = 0.
  - Reset asserted mid-operation discards all queued entries immediately. Nothing is delivered after release.
- Routing:
  - dest = s_meta.data[DEST_BIT], decoded combinationally.
  - s_meta.ready = !full[dest]. The registered full flag is used; a same-cycle pop gives no credit.
  - The input never stalls on the non-selected queue.
- Push: s_meta.valid & s_meta.ready writes data to queue[dest], advances wr_ptr[dest], increments count[dest].
- Output:
  - m_meta_x.valid = (count_x != 0).
  - m_meta_x.data = head entry when valid, else 0.
  - Pop when m_meta_x.valid & m_meta_x.ready: advance rd_ptr_x, decrement count_x.
- Latency: 1 cycle. A word accepted on edge N is presented on m_meta_x.valid after edge N (no combinational bypass).
- Ordering:
  - Strict FIFO order per output.
  - No ordering guarantee between outputs.
- Pointers: $clog2(QDEPTH) bits, natural wrap at QDEPTH.
- Count:
  - Separate counter, QDEPTH+1 states.
  - Simultaneous push and pop on the same queue: count unchanged, both pointers advance.
- Boundaries:
  - Full: count == QDEPTH. Ready is low for that destination only; a word waiting for the full queue holds s_meta (head-of-line on input, by design).
  - Empty: count == 0, valid low.
  - Pop and push on a queue at count==1: valid stays high and the new word follows the popped one.
  - valid without a matching ready never loses data. Output data is stable while valid & !ready.
- used_x = count_x, registered.

Decomposition:
- Shared package (lynxTypes): meta width constants (DATA_BITS defaults) and the routing-bit index constant for each user.
- One sub-module is natural: meta_queue, a single-clock FIFO instantiated twice.
  - Ports: aclk, aresetn, push/data_in/full, pop/data_out/empty, count.
  - Storage is distributed RAM array; pointers and count as above.
- The top level holds only the dest decode, ready mux and two meta_queue instances.

Test Plan:
- Reset release, then 3 words with data=0x10,0x12,0x14 (DEST_BIT=0 clear), m_meta_0.ready=1 -> m_meta_0 emits 0x10,0x12,0x14 in order, each one cycle after acceptance; m_meta_1.valid stays 0.
- m_meta_1.ready=0; push 4 words with bit0=1 -> used_1 counts 1..4. 5th bit0=1 word: s_meta.ready=0. Then a bit0=0 word waiting is also blocked (HOL). Raise m_meta_1.ready one cycle -> ready returns, 5th word accepted.
- m_meta_1 held stalled and full; stream bit0=0 words before any bit0=1 word -> all delivered on m_meta_0 at 1 word/cycle, used_1 stays 4.
- Queue 0 at count=2, simultaneous push and pop for 10 cycles -> used_0 stays 2, outputs in input order, pointers wrap without loss or duplication.
- With 3 entries queued in each queue, pulse aresetn low mid-cycle (asynchronously) -> all valids and ready drop immediately, used_x=0. No stale word appears after release; next push is delivered first.
- Randomized dest/valid/ready, 10k words, scoreboard per output -> exact per-output order, zero loss. Data stable while valid & !ready.

Source files
------------

// File: rtl/meta_demux_1_2_pkg.sv
// meta_demux_1_2_pkg: shared meta width, queue depth and routing-bit constants
package meta_demux_1_2_pkg;
    localparam int META_DATA_BITS = 96;
    localparam int META_QDEPTH    = 4;
    localparam int META_DEST_BIT  = 0;
endpackage

// File: rtl/meta_intf.sv
// metaIntf: valid/ready meta stream with a DATA_BITS-wide word
interface metaIntf
    import meta_demux_1_2_pkg::*;
#(
    parameter int DATA_BITS = META_DATA_BITS
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data;
    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/meta_queue.sv
// meta_queue: single-clock FIFO with separate occupancy counter, zero-on-empty output
module meta_queue
    import meta_demux_1_2_pkg::*;
#(
    parameter int QDEPTH    = META_QDEPTH,
    parameter int DATA_BITS = META_DATA_BITS
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         push,
    input  logic [DATA_BITS-1:0]         data_in,
    output logic                         full,
    input  logic                         pop,
    output logic [DATA_BITS-1:0]         data_out,
    output logic                         empty,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [DATA_BITS-1:0] mem [QDEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = count == CW'(QDEPTH);
    assign empty    = count == '0;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign data_out = empty ? '0 : mem[rd_ptr];

    // storage is never reset; only pointers and count define contents
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    // pointers wrap naturally at QDEPTH; push and pop together leave count unchanged
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/meta_demux_1_2.sv
// meta_demux_1_2: routes each meta word to one of two queued outputs by a destination bit
module meta_demux_1_2
    import meta_demux_1_2_pkg::*;
#(
    parameter int QDEPTH    = META_QDEPTH,
    parameter int DATA_BITS = META_DATA_BITS,
    parameter int DEST_BIT  = META_DEST_BIT
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    metaIntf.s                          s_meta,
    metaIntf.m                          m_meta_0,
    metaIntf.m                          m_meta_1,
    output logic [$clog2(QDEPTH+1)-1:0] used_0,
    output logic [$clog2(QDEPTH+1)-1:0] used_1
);
    logic dest;
    logic full_0;
    logic full_1;
    logic empty_0;
    logic empty_1;
    logic acc;

    // ready looks only at the selected queue's registered full flag, and is held low in reset
    assign dest         = s_meta.data[DEST_BIT];
    assign s_meta.ready = aresetn & ~(dest ? full_1 : full_0);
    assign acc          = s_meta.valid & s_meta.ready;
    assign m_meta_0.valid = ~empty_0;
    assign m_meta_1.valid = ~empty_1;

    meta_queue #(.QDEPTH(QDEPTH), .DATA_BITS(DATA_BITS)) u_q0 (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (acc & ~dest),
        .data_in  (s_meta.data),
        .full     (full_0),
        .pop      (m_meta_0.ready),
        .data_out (m_meta_0.data),
        .empty    (empty_0),
        .count    (used_0)
    );

    meta_queue #(.QDEPTH(QDEPTH), .DATA_BITS(DATA_BITS)) u_q1 (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (acc & dest),
        .data_in  (s_meta.data),
        .full     (full_1),
        .pop      (m_meta_1.ready),
        .data_out (m_meta_1.data),
        .empty    (empty_1),
        .count    (used_1)
    );
endmodule

// File: tb/tb_meta_demux_1_2.sv
// tb_meta_demux_1_2: directed and random self-checking bench for meta_demux_1_2
module tb_meta_demux_1_2;
    logic       aclk = 1'b0;
    logic       aresetn;
    logic [2:0] used_0;
    logic [2:0] used_1;
    int         checks = 0;
    int         errors = 0;

    metaIntf #(.DATA_BITS(96)) s_if ();
    metaIntf #(.DATA_BITS(96)) m0_if ();
    metaIntf #(.DATA_BITS(96)) m1_if ();

    meta_demux_1_2 #(.QDEPTH(4), .DATA_BITS(96), .DEST_BIT(0)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_meta   (s_if),
        .m_meta_0 (m0_if),
        .m_meta_1 (m1_if),
        .used_0   (used_0),
        .used_1   (used_1)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [95:0] d);
        s_if.valid = v;
        s_if.data  = d;
        #1;
    endtask

    logic [95:0] q0[$];
    logic [95:0] q1[$];
    logic [95:0] word;
    logic [95:0] prev_d0, prev_d1;
    logic        pend, stall0, stall1;
    int          sent, cyc;

    initial begin
        aresetn = 1'b0;
        s_if.valid = 1'b0;
        s_if.data = '0;
        m0_if.ready = 1'b0;
        m1_if.ready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_ready", 96'(s_if.ready), 96'(0));
        chk("rst_v0", 96'(m0_if.valid), 96'(0));
        chk("rst_v1", 96'(m1_if.valid), 96'(0));
        chk("rst_d0", m0_if.data, 96'(0));
        chk("rst_used0", 96'(used_0), 96'(0));
        chk("rst_used1", 96'(used_1), 96'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        tick();

        // in-order delivery on output 0 with one cycle latency
        m0_if.ready = 1'b1;
        drive(1'b1, 96'h10);
        chk("t1_ready", 96'(s_if.ready), 96'(1));
        chk("t1_nobypass", 96'(m0_if.valid), 96'(0));
        tick();
        chk("t1_v0", 96'(m0_if.valid), 96'(1));
        chk("t1_d10", m0_if.data, 96'h10);
        drive(1'b1, 96'h12);
        tick();
        chk("t1_d12", m0_if.data, 96'h12);
        drive(1'b1, 96'h14);
        tick();
        chk("t1_d14", m0_if.data, 96'h14);
        chk("t1_used0", 96'(used_0), 96'(1));
        drive(1'b0, 96'h0);
        tick();
        chk("t1_empty0", 96'(m0_if.valid), 96'(0));
        chk("t1_v1", 96'(m1_if.valid), 96'(0));

        // fill queue 1 and check input head-of-line block
        m0_if.ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 96'(32'h21 + 2 * i));
            tick();
            chk("t2_used1", 96'(used_1), 96'(i));
        end
        drive(1'b1, 96'h51);
        chk("t2_full_ready", 96'(s_if.ready), 96'(0));
        tick();
        chk("t2_hold_used1", 96'(used_1), 96'(4));
        chk("t2_hol_used0", 96'(used_0), 96'(0));
        m1_if.ready = 1'b1;
        #1;
        chk("t2_nocredit", 96'(s_if.ready), 96'(0));
        tick();
        m1_if.ready = 1'b0;
        #1;
        chk("t2_ready_back", 96'(s_if.ready), 96'(1));
        chk("t2_used1_3", 96'(used_1), 96'(3));
        chk("t2_head1", m1_if.data, 96'h25);
        tick();
        chk("t2_used1_4", 96'(used_1), 96'(4));
        drive(1'b0, 96'h0);

        // output 0 streams while output 1 is full and stalled
        m0_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 96'(32'h40 + 2 * i));
            chk("t3_ready", 96'(s_if.ready), 96'(1));
            tick();
            chk("t3_d0", m0_if.data, 96'(32'h40 + 2 * i));
            chk("t3_used1", 96'(used_1), 96'(4));
        end
        drive(1'b0, 96'h0);
        tick();
        chk("t3_empty0", 96'(m0_if.valid), 96'(0));

        // steady push+pop at count 2 across pointer wrap
        m0_if.ready = 1'b0;
        drive(1'b1, 96'h60);
        tick();
        drive(1'b1, 96'h62);
        tick();
        chk("t4_used0_2", 96'(used_0), 96'(2));
        m0_if.ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 96'(32'h64 + 2 * k));
            chk("t4_head", m0_if.data, 96'(32'h60 + 2 * k));
            tick();
            chk("t4_used0", 96'(used_0), 96'(2));
        end
        drive(1'b0, 96'h0);
        chk("t4_drain_a", m0_if.data, 96'h74);
        tick();
        chk("t4_drain_b", m0_if.data, 96'h76);
        tick();
        chk("t4_empty", 96'(m0_if.valid), 96'(0));

        // asynchronous reset with both queues holding 3 words
        m0_if.ready = 1'b0;
        m1_if.ready = 1'b1;
        tick();
        m1_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 96'(32'h70 + 2 * i));
            tick();
        end
        drive(1'b0, 96'h0);
        chk("t5_pre_used0", 96'(used_0), 96'(3));
        chk("t5_pre_used1", 96'(used_1), 96'(3));
        #2;
        aresetn = 1'b0;
        #1;
        chk("t5_v0", 96'(m0_if.valid), 96'(0));
        chk("t5_v1", 96'(m1_if.valid), 96'(0));
        chk("t5_ready", 96'(s_if.ready), 96'(0));
        chk("t5_used0", 96'(used_0), 96'(0));
        chk("t5_used1", 96'(used_1), 96'(0));
        chk("t5_d1", m1_if.data, 96'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        chk("t5_post_v0", 96'(m0_if.valid), 96'(0));
        chk("t5_post_v1", 96'(m1_if.valid), 96'(0));
        m0_if.ready = 1'b1;
        drive(1'b1, 96'h80);
        tick();
        drive(1'b0, 96'h0);
        chk("t5_first", m0_if.data, 96'h80);
        chk("t5_post_used0", 96'(used_0), 96'(1));
        tick();

        // random traffic with per-output scoreboards
        pend = 1'b0;
        sent = 0;
        stall0 = 1'b0;
        stall1 = 1'b0;
        prev_d0 = '0;
        prev_d1 = '0;
        cyc = 0;
        while ((sent < 10000 || q0.size() != 0 || q1.size() != 0) && cyc < 60000) begin
            if (!pend && sent < 10000 && ($urandom % 4) != 0) begin
                word = {$urandom, $urandom, $urandom};
                pend = 1'b1;
            end
            s_if.valid  = pend;
            s_if.data   = pend ? word : 96'h0;
            m0_if.ready = ($urandom % 4) != 0;
            m1_if.ready = ($urandom % 3) != 0;
            #1;
            if (stall0) chk("rnd_stable0", m0_if.data, prev_d0);
            if (stall1) chk("rnd_stable1", m1_if.data, prev_d1);
            if (m0_if.valid && m0_if.ready) begin
                chk("rnd_order0", m0_if.data, q0.size() != 0 ? q0[0] : 96'hx);
                if (q0.size() != 0) void'(q0.pop_front());
            end
            if (m1_if.valid && m1_if.ready) begin
                chk("rnd_order1", m1_if.data, q1.size() != 0 ? q1[0] : 96'hx);
                if (q1.size() != 0) void'(q1.pop_front());
            end
            stall0  = m0_if.valid & ~m0_if.ready;
            stall1  = m1_if.valid & ~m1_if.ready;
            prev_d0 = m0_if.data;
            prev_d1 = m1_if.data;
            if (s_if.valid && s_if.ready) begin
                if (word[0]) q1.push_back(word);
                else q0.push_back(word);
                pend = 1'b0;
                sent++;
            end
            tick();
            cyc++;
        end
        s_if.valid = 1'b0;
        chk("rnd_timeout", 96'(cyc < 60000), 96'(1));
        chk("rnd_sent", 96'(sent), 96'(10000));
        chk("rnd_q0_left", 96'(q0.size()), 96'(0));
        chk("rnd_q1_left", 96'(q1.size()), 96'(0));
        tick();
        chk("rnd_used0", 96'(used_0), 96'(0));
        chk("rnd_used1", 96'(used_1), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
